// File: rtl/door_occupancy_tracker_pkg.sv
// home_auto_pkg: shared state encoding, beam levels and width helper for the door tracker
package home_auto_pkg;
  typedef enum logic [2:0] {IDLE, EN_A, EN_AB, EN_B, EX_B, EX_BA, EX_A, ERR} occ_state_t;
  localparam logic IR_BROKEN = 1'b1;
  localparam logic IR_CLEAR = 1'b0;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/door_occupancy_tracker_if.sv
// door_occupancy_tracker_if: beam inputs and occupancy outputs of the door tracker
interface door_occupancy_tracker_if #(parameter int CNT_W = 8);
  logic ir_sensor1;
  logic ir_sensor2;
  logic count_clr;
  logic [CNT_W-1:0] curr_count;
  logic occupied;
  logic entry_pulse;
  logic exit_pulse;
  logic seq_error;
  logic sat_flag;
  modport master(output ir_sensor1, ir_sensor2, count_clr,
                 input curr_count, occupied, entry_pulse, exit_pulse, seq_error, sat_flag);
  modport slave(input ir_sensor1, ir_sensor2, count_clr,
                output curr_count, occupied, entry_pulse, exit_pulse, seq_error, sat_flag);
endinterface

// File: rtl/door_occupancy_tracker_filter.sv
// ir_input_filter: 2-FF synchronizer, plus DEB_CYC-sample debounce when DOOR_DEBOUNCE_EN is defined
module ir_input_filter #(
  parameter int DEB_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);
`ifdef DOOR_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif
  logic [1:0] sync;
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync <= '0;
    else sync <= {sync[0], raw};
  generate
    if (DEB_EN && DEB_CYC > 0) begin : g_deb
      localparam int DW = home_auto_pkg::clog2(DEB_CYC + 1);
      logic [DW-1:0] cnt;
      always_ff @(posedge clk or negedge reset)
        if (!reset) begin
          cnt <= '0;
          filt <= 1'b0;
        end else if (sync[1] == filt) cnt <= '0;
        else if (cnt == DW'(DEB_CYC - 1)) begin
          cnt <= '0;
          filt <= sync[1];
        end else cnt <= cnt + 1'b1;
    end else begin : g_raw
      assign filt = sync[1];
    end
  endgenerate
endmodule

// File: rtl/door_occupancy_tracker.sv
// door_occupancy_tracker: beam-sequence FSM with saturating occupant count (DOOR_DEBOUNCE_EN adds input debounce)
module door_occupancy_tracker
  import home_auto_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int MAX_OCC = 200,
  parameter int TIMEOUT_CYC = 50000,
  parameter int DEB_CYC = 16
) (
  input logic clk,
  input logic reset,
  door_occupancy_tracker_if.slave bus
);
  localparam int TW = clog2(TIMEOUT_CYC + 1);
  localparam logic [1:0] V_0 = {IR_CLEAR, IR_CLEAR};
  localparam logic [1:0] V_A = {IR_BROKEN, IR_CLEAR};
  localparam logic [1:0] V_B = {IR_CLEAR, IR_BROKEN};
  localparam logic [1:0] V_AB = {IR_BROKEN, IR_BROKEN};
  logic s1, s2, tout, ent, ext, err, sat;
  logic ent_q, ext_q, err_q, sat_q, occ_q;
  logic [1:0] v;
  logic [TW-1:0] timer;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  occ_state_t state, nxt;
  ir_input_filter #(.DEB_CYC(DEB_CYC)) u_f1 (.clk, .reset, .raw(bus.ir_sensor1), .filt(s1));
  ir_input_filter #(.DEB_CYC(DEB_CYC)) u_f2 (.clk, .reset, .raw(bus.ir_sensor2), .filt(s2));
  assign v = {s1, s2};
  assign tout = state != IDLE && state != ERR && timer == TW'(TIMEOUT_CYC - 1);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = v == V_A ? EN_A : v == V_B ? EX_B : v == V_AB ? ERR : IDLE;
      EN_A:  nxt = v == V_AB ? EN_AB : v == V_0 ? IDLE : v == V_B ? ERR : EN_A;
      EN_AB: nxt = v == V_B ? EN_B : v == V_A ? EN_A : v == V_0 ? ERR : EN_AB;
      EN_B:  nxt = v == V_0 ? IDLE : v == V_AB ? EN_AB : v == V_A ? ERR : EN_B;
      EX_B:  nxt = v == V_AB ? EX_BA : v == V_0 ? IDLE : v == V_A ? ERR : EX_B;
      EX_BA: nxt = v == V_A ? EX_A : v == V_B ? EX_B : v == V_0 ? ERR : EX_BA;
      EX_A:  nxt = v == V_0 ? IDLE : v == V_AB ? EX_BA : v == V_B ? ERR : EX_A;
      default: nxt = v == V_0 ? IDLE : ERR;
    endcase
    if (tout) nxt = ERR;
  end
  assign ent = state == EN_B && nxt == IDLE;
  assign ext = state == EX_A && nxt == IDLE;
  assign err = nxt == ERR && state != ERR;
  assign sat = (ent && cnt == CNT_W'(MAX_OCC)) || (ext && cnt == '0);
  assign cnt_nxt = bus.count_clr ? '0 : sat ? cnt : ent ? cnt + 1'b1 : ext ? cnt - 1'b1 : cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      timer <= '0;
      cnt <= '0;
      occ_q <= 1'b0;
      ent_q <= 1'b0;
      ext_q <= 1'b0;
      err_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      state <= nxt;
      timer <= (nxt != state || state == IDLE || state == ERR) ? '0 : timer + 1'b1;
      cnt <= cnt_nxt;
      occ_q <= cnt_nxt != '0;
      ent_q <= ent;
      ext_q <= ext;
      err_q <= err;
      sat_q <= sat;
    end
  assign bus.curr_count = cnt;
  assign bus.occupied = occ_q;
  assign bus.entry_pulse = ent_q;
  assign bus.exit_pulse = ext_q;
  assign bus.seq_error = err_q;
  assign bus.sat_flag = sat_q;
endmodule

// File: tb/tb_door_occupancy_tracker.sv
// tb_door_occupancy_tracker: directed and random beam sequences checked against a walk-based reference model
module tb_door_occupancy_tracker;
  localparam int MAX = 3;
  localparam int T = 20;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  door_occupancy_tracker_if #(.CNT_W(8)) bus();
  door_occupancy_tracker #(.CNT_W(8), .MAX_OCC(MAX), .TIMEOUT_CYC(T), .DEB_CYC(16)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  int compared = 0;
  int mismatched = 0;
  int mode;
  int dwell;
  int m_cnt;
  logic [1:0] lv, p0, p1, cur;
  logic m_ent, m_ext, m_err, m_sat;
  int r, n;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask
  task automatic check_all();
    chk("curr_count", 32'(bus.curr_count), m_cnt);
    chk("occupied", 32'(bus.occupied), 32'(m_cnt != 0));
    chk("entry_pulse", 32'(bus.entry_pulse), 32'(m_ent));
    chk("exit_pulse", 32'(bus.exit_pulse), 32'(m_ext));
    chk("seq_error", 32'(bus.seq_error), 32'(m_err));
    chk("sat_flag", 32'(bus.sat_flag), 32'(m_sat));
  endtask
  task automatic model_reset();
    mode = 0;
    dwell = 0;
    m_cnt = 0;
    lv = 2'b00;
    p0 = 2'b00;
    p1 = 2'b00;
    {m_ent, m_ext, m_err, m_sat} = 4'b0;
  endtask
  // mode: 0 idle, 1 entering, 2 leaving, 3 waiting for clear beams after an error
  task automatic model_step(input logic [1:0] v, input logic clr);
    {m_ent, m_ext, m_err, m_sat} = 4'b0;
    if (mode == 0) begin
      if (v == 2'b10 || v == 2'b01) begin
        mode = (v == 2'b10) ? 1 : 2;
        lv = v;
        dwell = 0;
      end else if (v == 2'b11) begin
        mode = 3;
        m_err = 1'b1;
      end
    end else if (mode == 3) begin
      if (v == 2'b00) mode = 0;
    end else if (dwell == T - 1) begin
      mode = 3;
      m_err = 1'b1;
    end else if (v == lv) dwell++;
    else if ((v ^ lv) == 2'b11) begin
      mode = 3;
      m_err = 1'b1;
    end else if (v == 2'b00) begin
      if (lv == ((mode == 1) ? 2'b01 : 2'b10)) begin
        if (mode == 1) m_ent = 1'b1;
        else m_ext = 1'b1;
      end
      mode = 0;
    end else begin
      lv = v;
      dwell = 0;
    end
    if (m_ent) begin
      if (m_cnt == MAX) m_sat = 1'b1;
      else m_cnt++;
    end
    if (m_ext) begin
      if (m_cnt == 0) m_sat = 1'b1;
      else m_cnt--;
    end
    if (clr) m_cnt = 0;
  endtask
  task automatic tick(input logic [1:0] v, input logic clr);
    check_all();
    bus.ir_sensor1 = v[1];
    bus.ir_sensor2 = v[0];
    bus.count_clr = clr;
    model_step(p1, clr);
    p1 = p0;
    p0 = v;
    @(negedge clk);
  endtask
  task automatic hold(input logic [1:0] v, input int cycles);
    repeat (cycles) tick(v, 1'b0);
  endtask
  task automatic walk(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c, input logic [1:0] d);
    hold(a, 5);
    hold(b, 5);
    hold(c, 5);
    hold(d, 5);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    bus.ir_sensor1 = 1'b0;
    bus.ir_sensor2 = 1'b0;
    bus.count_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b1;
    walk(2'b10, 2'b11, 2'b01, 2'b00);
    chk("entry_count", 32'(bus.curr_count), 1);
    chk("entry_occupied", 32'(bus.occupied), 1);
    walk(2'b01, 2'b11, 2'b10, 2'b00);
    chk("exit_count", 32'(bus.curr_count), 0);
    walk(2'b01, 2'b11, 2'b10, 2'b00);
    chk("exit_at_zero", 32'(bus.curr_count), 0);
    walk(2'b10, 2'b11, 2'b10, 2'b00);
    chk("backout_count", 32'(bus.curr_count), 0);
    hold(2'b11, 5);
    hold(2'b00, 5);
    walk(2'b10, 2'b11, 2'b01, 2'b00);
    chk("after_illegal", 32'(bus.curr_count), 1);
    hold(2'b10, 25);
    hold(2'b00, 5);
    walk(2'b10, 2'b11, 2'b01, 2'b00);
    chk("after_timeout", 32'(bus.curr_count), 2);
    walk(2'b10, 2'b11, 2'b01, 2'b00);
    walk(2'b10, 2'b11, 2'b01, 2'b00);
    chk("saturated", 32'(bus.curr_count), MAX);
    hold(2'b10, 5);
    hold(2'b11, 5);
    hold(2'b01, 5);
    tick(2'b00, 1'b0);
    tick(2'b00, 1'b0);
    tick(2'b00, 1'b1);
    hold(2'b00, 3);
    chk("clr_on_entry", 32'(bus.curr_count), 0);
    walk(2'b10, 2'b11, 2'b01, 2'b00);
    hold(2'b10, 5);
    hold(2'b11, 5);
    do_reset();
    chk("reset_count", 32'(bus.curr_count), 0);
    hold(2'b00, 5);
    walk(2'b10, 2'b11, 2'b01, 2'b00);
    chk("post_reset_entry", 32'(bus.curr_count), 1);
    cur = 2'b00;
    for (int i = 0; i < 700; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) cur ^= ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      else if (r < 82) cur = 2'b00;
      else cur = 2'($urandom_range(0, 3));
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 26) : $urandom_range(1, 6);
      for (int k = 0; k < n; k++) tick(cur, $urandom_range(0, 59) == 0);
      if ($urandom_range(0, 149) == 0) do_reset();
    end
    hold(2'b00, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
